// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg : shared encodings and pattern helpers for the small-float datapath
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fp_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  // Bit positions inside the 4-bit flags vector {invalid, overflow, underflow, inexact}
  localparam int c_FLG_INV = 3;
  localparam int c_FLG_OVF = 2;
  localparam int c_FLG_UNF = 1;
  localparam int c_FLG_INX = 0;

  localparam logic c_RM_RNE = 1'b0;
  localparam logic c_RM_RTZ = 1'b1;

  function automatic logic [31:0] fp_bias(input int exp_w);
    return 32'((1 << (exp_w - 1)) - 1);
  endfunction

  // Magnitude patterns (sign bit excluded); callers cast to their own width
  function automatic logic [31:0] fp_inf(input int exp_w, input int man_w);
    return 32'(((1 << exp_w) - 1) << man_w);
  endfunction

  function automatic logic [31:0] fp_nan(input int exp_w, input int man_w);
    return 32'((((1 << exp_w) - 1) << man_w) | (1 << (man_w - 1)));
  endfunction

  function automatic logic [31:0] fp_max_fin(input int exp_w, input int man_w);
    return 32'((((1 << exp_w) - 2) << man_w) | ((1 << man_w) - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_round.sv
// ----------------------------------------------------------------------------
// fp_round : normalise a raw significand product and round it to MAN_W bits
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp_round
  import fp_pkg::*;
#(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3
) (
  input  logic [2*MAN_W+1:0]      i_prod,
  input  logic signed [EXP_W+1:0] i_exp,
  input  logic                    i_rm,
  output logic [MAN_W-1:0]        o_frac,
  output logic signed [EXP_W+1:0] o_exp,
  output logic                    o_inexact
);

  localparam int c_P = 2*MAN_W + 2;

  logic [c_P-1:0] w_norm;
  logic           w_guard;
  logic           w_sticky;
  logic           w_lsb;
  logic           w_up;
  logic [MAN_W:0] w_sum;

  // Align so the hidden one always sits at bit c_P-1
  assign w_norm    = i_prod[c_P-1] ? i_prod : (i_prod << 1);
  assign w_lsb     = w_norm[MAN_W+1];
  assign w_guard   = w_norm[MAN_W];
  assign w_sticky  = |w_norm[MAN_W-1:0];
  assign w_up      = (i_rm == c_RM_RNE) && w_guard && (w_sticky || w_lsb);
  assign w_sum     = {1'b0, w_norm[c_P-2 -: MAN_W]} + (MAN_W+1)'(w_up);

  assign o_frac    = w_sum[MAN_W-1:0];
  assign o_exp     = i_exp + $signed((EXP_W+2)'(i_prod[c_P-1]))
                           + $signed((EXP_W+2)'(w_sum[MAN_W]));
  assign o_inexact = w_guard || w_sticky;

endmodule

`default_nettype wire

// File: rtl/fp_mul_pipe.sv
// ----------------------------------------------------------------------------
// fp_mul_pipe : three-stage valid/ready floating-point multiplier with flags
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int c_W = 1 + EXP_W + MAN_W;
  localparam int c_P = 2*MAN_W + 2;
  localparam logic signed [EXP_W+1:0] c_BIAS     = (EXP_W+2)'(fp_bias(EXP_W));
  localparam logic signed [EXP_W+1:0] c_EXP_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] c_EXP_ZERO = '0;
  localparam logic [c_W-1:0] c_NAN     = c_W'(fp_nan(EXP_W, MAN_W));
  localparam logic [c_W-2:0] c_INF_MAG = (c_W-1)'(fp_inf(EXP_W, MAN_W));
  localparam logic [c_W-2:0] c_MAX_MAG = (c_W-1)'(fp_max_fin(EXP_W, MAN_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return CLS_ZERO;
    if (e == '1) return (f == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  logic w_en1, w_en2, w_en3;
  logic r1_valid, r2_valid;

  // Stage S1 combinational inputs
  fp_class_e                w_cls_a, w_cls_b, w_cls;
  logic [c_P-1:0]           w_sig_a, w_sig_b;
  logic signed [EXP_W+1:0]  w_exp_sum;

  fp_class_e                r1_cls;
  logic                     r1_sign, r1_rm;
  logic signed [EXP_W+1:0]  r1_exp;
  logic [c_P-1:0]           r1_prod;

  logic [MAN_W-1:0]         w_frac;
  logic signed [EXP_W+1:0]  w_exp_rnd;
  logic                     w_inexact;

  fp_class_e                r2_cls;
  logic                     r2_sign, r2_rm, r2_inexact;
  logic signed [EXP_W+1:0]  r2_exp;
  logic [MAN_W-1:0]         r2_frac;

  logic [c_W-1:0]           w_res;
  logic [3:0]               w_flags;

  assign w_en3    = !out_valid || out_ready;
  assign w_en2    = !r2_valid || w_en3;
  assign w_en1    = !r1_valid || w_en2;
  assign in_ready = w_en1;

  assign w_cls_a   = classify(a[c_W-2 -: EXP_W], a[MAN_W-1:0]);
  assign w_cls_b   = classify(b[c_W-2 -: EXP_W], b[MAN_W-1:0]);
  assign w_sig_a   = {{(MAN_W+1){1'b0}}, 1'b1, a[MAN_W-1:0]};
  assign w_sig_b   = {{(MAN_W+1){1'b0}}, 1'b1, b[MAN_W-1:0]};
  assign w_exp_sum = $signed({2'b00, a[c_W-2 -: EXP_W]})
                   + $signed({2'b00, b[c_W-2 -: EXP_W]}) - c_BIAS;

  always_comb begin
    w_cls = CLS_NORM;
    if (w_cls_a == CLS_NAN || w_cls_b == CLS_NAN ||
        (w_cls_a == CLS_ZERO && w_cls_b == CLS_INF) ||
        (w_cls_a == CLS_INF && w_cls_b == CLS_ZERO))
      w_cls = CLS_NAN;
    else if (w_cls_a == CLS_INF || w_cls_b == CLS_INF)
      w_cls = CLS_INF;
    else if (w_cls_a == CLS_ZERO || w_cls_b == CLS_ZERO)
      w_cls = CLS_ZERO;
  end

  fp_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .i_prod    (r1_prod),
    .i_exp     (r1_exp),
    .i_rm      (r1_rm),
    .o_frac    (w_frac),
    .o_exp     (w_exp_rnd),
    .o_inexact (w_inexact)
  );

  // Stage S3: range check and pack
  always_comb begin
    w_res   = '0;
    w_flags = '0;
    case (r2_cls)
      CLS_NAN: begin
        w_res              = c_NAN;
        w_flags[c_FLG_INV] = 1'b1;
      end
      CLS_INF:  w_res = {r2_sign, c_INF_MAG};
      CLS_ZERO: w_res = {r2_sign, {(c_W-1){1'b0}}};
      default: begin
        if (r2_exp >= c_EXP_MAX) begin
          w_res              = {r2_sign, (r2_rm == c_RM_RNE) ? c_INF_MAG : c_MAX_MAG};
          w_flags[c_FLG_OVF] = 1'b1;
          w_flags[c_FLG_INX] = 1'b1;
        end else if (r2_exp <= c_EXP_ZERO) begin
          w_res              = {r2_sign, {(c_W-1){1'b0}}};
          w_flags[c_FLG_UNF] = 1'b1;
          w_flags[c_FLG_INX] = 1'b1;
        end else begin
          w_res              = {r2_sign, r2_exp[EXP_W-1:0], r2_frac};
          w_flags[c_FLG_INX] = r2_inexact;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid  <= 1'b0;
      r2_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      if (w_en1) r1_valid <= in_valid;
      if (w_en2) r2_valid <= r1_valid;
      if (w_en3) begin
        out_valid <= r2_valid;
        if (r2_valid) begin
          result <= w_res;
          flags  <= w_flags;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_en1 && in_valid) begin
      r1_cls  <= w_cls;
      r1_sign <= a[c_W-1] ^ b[c_W-1];
      r1_rm   <= rm;
      r1_exp  <= w_exp_sum;
      r1_prod <= w_sig_a * w_sig_b;
    end
    if (w_en2 && r1_valid) begin
      r2_cls     <= r1_cls;
      r2_sign    <= r1_sign;
      r2_rm      <= r1_rm;
      r2_exp     <= w_exp_rnd;
      r2_frac    <= w_frac;
      r2_inexact <= w_inexact;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
// ----------------------------------------------------------------------------
// tb_fp_mul_pipe : scoreboard bench for fp_mul_pipe using a real-valued model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fp_mul_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       rm = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic [3:0] flags;

  int          n_err = 0;
  int          n_chk = 0;
  int          cyc = 0;
  logic [11:0] sb[$];
  int          pop_cyc[$];
  bit          hold = 1'b0;
  logic [11:0] held = '0;

  fp_mul_pipe #(.EXP_W(4), .MAN_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  // Exact real-valued product, then rounded to E4M3 (bias 7)
  function automatic logic [11:0] model(input logic [7:0] x, input logic [7:0] y, input logic r);
    int  ex, ey, fx, fy, e, t, be;
    bit  s, nx, ny, ix, iy, zx, zy, inx;
    real m, sc, rem;
    ex = int'(x[6:3]); ey = int'(y[6:3]); fx = int'(x[2:0]); fy = int'(y[2:0]);
    s  = x[7] ^ y[7];
    nx = (ex == 15) && (fx != 0); ny = (ey == 15) && (fy != 0);
    ix = (ex == 15) && (fx == 0); iy = (ey == 15) && (fy == 0);
    zx = (ex == 0); zy = (ey == 0);
    if (nx || ny || (zx && iy) || (ix && zy)) return {8'h7C, 4'b1000};
    if (ix || iy) return {s, 7'h78, 4'b0000};
    if (zx || zy) return {s, 7'h00, 4'b0000};
    m = (1.0 + fx / 8.0) * (1.0 + fy / 8.0);
    e = ex + ey - 14;
    while (m >= 2.0) begin m = m / 2.0; e = e + 1; end
    sc  = m * 8.0;
    t   = int'($floor(sc));
    rem = sc - t;
    inx = (rem != 0.0);
    if (!r && (rem > 0.5 || (rem == 0.5 && (t % 2) == 1))) t = t + 1;
    if (t == 16) begin t = 8; e = e + 1; end
    be = e + 7;
    if (be >= 15) return {(r ? {s, 7'h77} : {s, 7'h78}), 4'b0101};
    if (be <= 0) return {s, 7'h00, 4'b0011};
    return {s, 4'(be), 3'(t - 8), 3'b000, inx};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic r, input bit rbp);
    int n;
    n = 0;
    a = x; b = y; rm = r; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      if (rbp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL send_timeout: in_ready stayed %0d, expected 1", in_ready);
    end else begin
      sb.push_back(model(x, y, r));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rbp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks hold stability
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        n_chk++;
        if ({result, flags} !== held) begin
          n_err++;
          $display("FAIL hold: got %0h expected %0h", {result, flags}, held);
        end
      end
      if (out_valid && !out_ready) begin
        hold = 1'b1;
        held = {result, flags};
      end else begin
        hold = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_chk++;
        pop_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got %0h expected none", {result, flags});
        end else begin
          held = sb.pop_front();
          if ({result, flags} !== held) begin
            n_err++;
            $display("FAIL result: got %0h expected %0h", {result, flags}, held);
          end
        end
      end
    end
  end

  initial begin
    int n0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_result", 32'(result), 0);
    chk("reset_flags", 32'(flags), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("in_ready_after_reset", 32'(in_ready), 1);

    // Latency of the first operation
    send(8'h3C, 8'h3C, 1'b0, 1'b0);
    chk("latency_c1", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("latency_c2", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("latency_c3", 32'(out_valid), 1);
    drain();

    send(8'h38, 8'hC0, 1'b0, 1'b0);
    send(8'h3D, 8'h3C, 1'b0, 1'b0);
    send(8'h3D, 8'h3C, 1'b1, 1'b0);
    send(8'h77, 8'h77, 1'b0, 1'b0);
    send(8'h77, 8'h77, 1'b1, 1'b0);
    send(8'h08, 8'h08, 1'b0, 1'b0);
    send(8'h00, 8'h78, 1'b0, 1'b0);
    send(8'h80, 8'h3C, 1'b0, 1'b0);
    send(8'h7A, 8'h3C, 1'b0, 1'b0);
    send(8'hF8, 8'h3C, 1'b1, 1'b0);
    drain();

    // Backpressure: three fill the pipe, the fourth must wait
    out_ready = 1'b0;
    n0 = pop_cyc.size();
    send(8'h3C, 8'h3D, 1'b0, 1'b0);
    send(8'h41, 8'h42, 1'b1, 1'b0);
    send(8'h50, 8'hB3, 1'b0, 1'b0);
    a = 8'h44; b = 8'h2F; rm = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h44, 8'h2F, 1'b0, 1'b0);
    send(8'h66, 8'h61, 1'b0, 1'b0);
    drain();
    chk("bp_pop_count", 32'(pop_cyc.size() - n0), 5);
    if (pop_cyc.size() - n0 == 5)
      chk("bp_one_per_cycle", 32'(pop_cyc[n0+4] - pop_cyc[n0]), 4);

    // Randomized stream with random gaps and backpressure
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end
    out_ready = 1'b1;
    drain();

    // Reset with two operations in flight
    out_ready = 1'b0;
    send(8'h3C, 8'h3C, 1'b0, 1'b0);
    send(8'h45, 8'h39, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rst_pre_out_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", 32'(out_valid), 0);
    chk("rst_async_result", 32'(result), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_output", 32'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
